// File: rtl/serial_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch filter, LSB-first deserializer, FWFT byte FIFO.
// Latency: valid_o rises about 2 + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT + 1 clocks after the falling start edge.
// Backpressure: bytes wait in the FIFO while ready_in is low; a good byte arriving at a full FIFO is dropped and flagged on overrun_o.
module serial_rx #(
    parameter int CLKS_PER_BIT = 9,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rxd_in,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_in,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]    HALF    = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]    LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bitn, bitn_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          ferr_nxt;
    logic          push_vld;

    logic          sync1, rxs;
    logic [1:0]    fill;
    logic          armed;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, pop, push_rdy;
    logic               ferr_q, ovr_q;

    // Synchronize the line and arm only once a genuine high has passed through both
    // flops; the reset-value ones in the synchronizer must not count as a real idle line.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= rxd_in;
            rxs   <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (rxs & fill[1]);
        end
    end

    // Receiver state register together with its bit timer, bit index and shift register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            cnt    <= '0;
            bitn   <= 3'd0;
            shreg  <= 8'h00;
            ferr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bitn   <= bitn_nxt;
            shreg  <= shreg_nxt;
            ferr_q <= ferr_nxt;
        end
    end

    // Frame decoding: mid-start validation, one sample per bit period, stop-bit check.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bitn_nxt  = bitn;
        shreg_nxt = shreg;
        ferr_nxt  = 1'b0;
        push_vld  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (armed && !rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_nxt  = '0;
                    bitn_nxt = 3'd0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt         = '0;
                    shreg_nxt[bitn] = rxs;
                    if (bitn == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bitn_nxt = bitn + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        push_vld  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                cnt_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign valid_o  = (count != '0);
    assign full     = (count == DEPTH_C);
    assign pop      = valid_o & ready_in;
    assign push_rdy = ~full | pop;
    assign data_o   = mem[rd_ptr];

    // FIFO storage and pointers; a full FIFO still accepts a push when a pop frees a slot the same cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= push_vld & ~push_rdy;
            if (push_vld && push_rdy) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if ((push_vld && push_rdy) && !pop) begin
                count <= count + 1'b1;
            end else if (!(push_vld && push_rdy) && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: 8N1 frames driven bit by bit on the falling clock edge.
// Outputs are sampled on the falling edge, away from the active rising edge.
// Error and overrun pulses are counted by a monitor and compared as deltas.
module tb_serial_rx;

    localparam int CPB = 9;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       rxd_in;
    logic       ready_in;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int base_f, base_o;
    int lat_cyc;
    logic [7:0] lat_dat;
    logic any_busy;

    serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rxd_in      (rxd_in),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_in    (ready_in),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitors: each count step is one cycle the pulse was high.
    always @(negedge clk_in) begin
        if (frame_err_o === 1'b1) ferr_cnt++;
        if (overrun_o === 1'b1) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_in = b[i];
            idle(CPB);
        end
        rxd_in = stop_bit;
        idle(CPB);
    endtask

    // Waits up to max cycles for valid_o; lat_cyc = -1 when it never came.
    task automatic wait_valid(input int max);
        lat_cyc = -1;
        lat_dat = 8'h00;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk_in);
            if (valid_o === 1'b1) begin
                lat_cyc = c;
                lat_dat = data_o;
                break;
            end
        end
    endtask

    task automatic pop_one();
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0;
        rxd_in   = 1'b1;
        ready_in = 1'b0;
        idle(4);

        // Reset state
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        rst_n_in = 1'b1;
        idle(6);

        // Single byte, consumer always ready: one-cycle valid about 89 cycles after the start edge
        base_f = ferr_cnt; base_o = ovr_cnt;
        ready_in = 1'b1;
        fork
            send_frame(8'h55, 1'b1);
            wait_valid(120);
        join
        chk("single_latency_in_range", (lat_cyc >= 88 && lat_cyc <= 90), 1);
        chk("single_data", lat_dat, 8'h55);
        chk("single_valid_one_cycle", valid_o, 0);
        ready_in = 1'b0;
        idle(3);
        chk("single_no_ferr", ferr_cnt - base_f, 0);
        chk("single_no_ovr", ovr_cnt - base_o, 0);

        // Back-to-back frames with the consumer stalled
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(4);
        chk("b2b_valid", valid_o, 1);
        chk("b2b_first", data_o, 8'hA3);
        pop_one();
        chk("b2b_second_valid", valid_o, 1);
        chk("b2b_second", data_o, 8'h0F);
        pop_one();
        chk("b2b_empty", valid_o, 0);

        // Glitch shorter than half a bit is rejected
        base_f = ferr_cnt;
        rxd_in = 1'b0;
        idle(3);
        rxd_in = 1'b1;
        idle(2);
        chk("glitch_busy_high", busy_o, 1);
        idle(10);
        chk("glitch_busy_low", busy_o, 0);
        chk("glitch_no_valid", valid_o, 0);
        chk("glitch_no_ferr", ferr_cnt - base_f, 0);

        // Framing error followed by a held-low line, then a good byte
        base_f = ferr_cnt;
        send_frame(8'h7E, 1'b0);
        idle(30);
        chk("ferr_busy_while_low", busy_o, 1);
        chk("ferr_one_pulse", ferr_cnt - base_f, 1);
        chk("ferr_no_byte", valid_o, 0);
        rxd_in = 1'b1;
        idle(6);
        chk("ferr_busy_released", busy_o, 0);
        send_frame(8'h31, 1'b1);
        idle(4);
        chk("ferr_next_valid", valid_o, 1);
        chk("ferr_next_data", data_o, 8'h31);
        pop_one();

        // Overrun: fifth byte dropped while the consumer is stalled
        base_o = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            idle(2);
        end
        chk("ovr_one_pulse", ovr_cnt - base_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_drain_data", data_o, i);
            pop_one();
        end
        chk("ovr_drain_empty", valid_o, 0);

        // Overrun avoided: pop lands on the same edge as the fifth push
        base_o = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1);
            idle(2);
        end
        fork
            send_frame(8'h05, 1'b1);
            begin
                idle(88);
                ready_in = 1'b1;
                @(negedge clk_in);
                ready_in = 1'b0;
            end
        join
        idle(2);
        chk("pushpop_no_ovr", ovr_cnt - base_o, 0);
        for (int i = 2; i <= 5; i++) begin
            chk("pushpop_drain_data", data_o, i);
            pop_one();
        end
        chk("pushpop_drain_empty", valid_o, 0);

        // Reset during bit 4 of 0xC3 with the line held low through reset release
        rxd_in = 1'b0;
        idle(CPB);
        rxd_in = 1'b1; idle(CPB);
        rxd_in = 1'b1; idle(CPB);
        rxd_in = 1'b0; idle(CPB);
        rxd_in = 1'b0; idle(CPB);
        rxd_in = 1'b0;
        idle(4);
        rst_n_in = 1'b0;
        idle(3);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 8'h00);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ferr", frame_err_o, 0);
        chk("midrst_ovr", overrun_o, 0);
        rst_n_in = 1'b1;
        any_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            if (busy_o !== 1'b0) any_busy = 1'b1;
        end
        chk("midrst_no_start_while_low", any_busy, 0);
        chk("midrst_no_valid", valid_o, 0);
        rxd_in = 1'b1;
        idle(10);
        ready_in = 1'b1;
        fork
            send_frame(8'h3C, 1'b1);
            wait_valid(120);
        join
        ready_in = 1'b0;
        chk("midrst_next_seen", (lat_cyc > 0), 1);
        chk("midrst_next_data", lat_dat, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
